// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin burst arbiter sharing one FIFO write port among N_REQ producers.
// Optional macro FIFO_ARB_PRIO0_EN: requester 0 wins every IDLE arbitration in which it requests.
module fifo_wr_arbiter #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 8,
  parameter int BURST  = 4,
  parameter int DEPTH  = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*DATA_W-1:0]  req_data,
  output logic [N_REQ-1:0]         gnt,
  input  logic                     buf_full,
  input  logic [7:0]               fifo_counter,
  output logic [DATA_W-1:0]        buf_in,
  output logic                     wr_en,
  output logic                     busy,
  output logic [$clog2(N_REQ)-1:0] cur_owner
);
  localparam int         OW         = $clog2(N_REQ);
  localparam logic [8:0] DEPTH_W    = 9'(DEPTH);
  localparam logic [7:0] BURST_LAST = 8'(BURST - 1);

  typedef enum logic {ST_IDLE = 1'b0, ST_OWN = 1'b1} state_t;

  state_t            state_r, state_nxt_s;
  logic [OW-1:0]     cur_owner_r, cur_owner_nxt_s;
  logic [OW-1:0]     last_owner_r, last_owner_nxt_s;
  logic [OW-1:0]     winner_s;
  logic [7:0]        burst_cnt_r, burst_cnt_nxt_s;
  logic [DATA_W-1:0] buf_in_r, buf_in_nxt_s;
  logic              wr_en_r, wr_en_nxt_s;
  logic              busy_r;
  logic [8:0]        occ_s;
  logic              accept_s;
  logic [N_REQ-1:0]  gnt_s;
  logic [DATA_W-1:0] slot_s [N_REQ];

  // First requester at or after last+1, wrapping modulo N_REQ.
  function automatic logic [OW-1:0] rr_pick(input logic [N_REQ-1:0] r, input logic [OW-1:0] last);
    logic [OW-1:0] pick;
    logic [OW-1:0] idx;
    logic          found;
    pick  = last;
    found = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = OW'((int'(last) + k) % N_REQ);
      if (!found && r[idx]) begin
        pick  = idx;
        found = 1'b1;
      end else begin
        found = found;
      end
    end
    return pick;
  endfunction

  for (genvar g = 0; g < N_REQ; g++) begin : g_slot
    assign slot_s[g] = req_data[g*DATA_W +: DATA_W];
  end

  // The registered wr_en is a write the FIFO has not counted yet, so it reserves a slot.
  assign occ_s    = {1'b0, fifo_counter} + {8'd0, wr_en_r};
  assign accept_s = (state_r == ST_OWN) && req[cur_owner_r] && !buf_full && (occ_s < DEPTH_W);

  // Winner of the next IDLE arbitration.
  always_comb begin
`ifdef FIFO_ARB_PRIO0_EN
    if (req[0]) begin
      winner_s = {OW{1'b0}};
    end else begin
      winner_s = rr_pick(req, last_owner_r);
    end
`else
    winner_s = rr_pick(req, last_owner_r);
`endif
  end

  // Next-state, grant and write-path decode.
  always_comb begin
    state_nxt_s      = state_r;
    cur_owner_nxt_s  = cur_owner_r;
    last_owner_nxt_s = last_owner_r;
    burst_cnt_nxt_s  = burst_cnt_r;
    buf_in_nxt_s     = buf_in_r;
    wr_en_nxt_s      = 1'b0;
    gnt_s            = {N_REQ{1'b0}};
    case (state_r)
      ST_IDLE: begin
        if (|req) begin
          state_nxt_s     = ST_OWN;
          cur_owner_nxt_s = winner_s;
          burst_cnt_nxt_s = 8'd0;
        end else begin
          state_nxt_s     = ST_IDLE;
        end
      end
      ST_OWN: begin
        if (accept_s) begin
          gnt_s[cur_owner_r] = 1'b1;
          wr_en_nxt_s        = 1'b1;
          buf_in_nxt_s       = slot_s[cur_owner_r];
          burst_cnt_nxt_s    = burst_cnt_r + 8'd1;
        end else begin
          burst_cnt_nxt_s    = burst_cnt_r;
        end
        if (!req[cur_owner_r] || (accept_s && (burst_cnt_r == BURST_LAST))) begin
          state_nxt_s      = ST_IDLE;
          last_owner_nxt_s = cur_owner_r;
          burst_cnt_nxt_s  = 8'd0;
        end else begin
          state_nxt_s      = ST_OWN;
        end
      end
      default: begin
        state_nxt_s     = ST_IDLE;
        burst_cnt_nxt_s = 8'd0;
      end
    endcase
  end

  // State and output registers; reset drops any in-flight write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      cur_owner_r  <= {OW{1'b0}};
      last_owner_r <= OW'(N_REQ - 1);
      burst_cnt_r  <= 8'd0;
      buf_in_r     <= {DATA_W{1'b0}};
      wr_en_r      <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      cur_owner_r  <= cur_owner_nxt_s;
      last_owner_r <= last_owner_nxt_s;
      burst_cnt_r  <= burst_cnt_nxt_s;
      buf_in_r     <= buf_in_nxt_s;
      wr_en_r      <= wr_en_nxt_s;
      busy_r       <= (state_nxt_s == ST_OWN);
    end
  end

  assign gnt       = gnt_s;
  assign buf_in    = buf_in_r;
  assign wr_en     = wr_en_r;
  assign busy      = busy_r;
  assign cur_owner = cur_owner_r;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: reference ownership model plus write-data scoreboard,
// directed scenarios followed by randomized traffic against a modelled FIFO.
`timescale 1ns/1ps
module tb_fifo_wr_arbiter;
  localparam int N     = 4;
  localparam int W     = 8;
  localparam int BURST = 4;
  localparam int DEPTH = 64;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] req;
  logic [N*W-1:0] req_data;
  logic [N-1:0] gnt;
  logic         buf_full;
  logic [7:0]   fifo_counter;
  logic [W-1:0] buf_in;
  logic         wr_en;
  logic         busy;
  logic [1:0]   cur_owner;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.N_REQ(N), .DATA_W(W), .BURST(BURST), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .gnt(gnt),
    .buf_full(buf_full), .fifo_counter(fifo_counter), .buf_in(buf_in),
    .wr_en(wr_en), .busy(busy), .cur_owner(cur_owner)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: owner index (-1 when nobody owns the port), words taken in this
  // ownership, the previous owner and whether a write is in flight.
  int           m_own, m_cur, m_last, m_cnt;
  logic         m_wr;
  logic [W-1:0] exp_q[$];

  always @(negedge clk) begin
    logic [N-1:0] eg;
    logic         acc;
    int           w;
    if (rst) begin
      m_own = -1; m_cur = 0; m_last = N - 1; m_cnt = 0; m_wr = 1'b0;
      check("rst_gnt", gnt, 0);
      check("rst_busy", busy, 0);
      check("rst_wr_en", wr_en, 0);
      check("rst_buf_in", buf_in, 0);
      check("rst_cur_owner", cur_owner, 0);
    end else begin
      eg  = '0;
      acc = 1'b0;
      if (m_own >= 0)
        acc = req[m_own] && !buf_full && ((int'(fifo_counter) + int'(m_wr)) < DEPTH);
      if (acc) eg[m_own] = 1'b1;
      check("gnt", gnt, eg);
      check("busy", busy, (m_own >= 0));
      check("cur_owner", cur_owner, m_cur);
      if (acc) begin
        exp_q.push_back(req_data[m_own*W +: W]);
        m_cnt++;
      end
      if (m_own < 0) begin
        w = -1;
`ifdef FIFO_ARB_PRIO0_EN
        if (req[0]) w = 0;
`endif
        for (int k = 1; k <= N; k++)
          if (w < 0 && req[(m_last + k) % N]) w = (m_last + k) % N;
        if (w >= 0) begin
          m_own = w; m_cur = w; m_cnt = 0;
        end
      end else if (!req[m_own] || m_cnt == BURST) begin
        m_last = m_own; m_own = -1; m_cnt = 0;
      end
      m_wr = acc;
    end
  end

  // Monitor: every registered write must match the oldest predicted word.
  always @(posedge clk) begin
    #2;
    if (!rst) begin
      if (exp_q.size() > 0) begin
        check("wr_en", wr_en, 1);
        check("buf_in", buf_in, exp_q.pop_front());
      end else begin
        check("wr_en_quiet", wr_en, 0);
      end
    end
  end

  logic         pre_wr;
  logic [N-1:0] pre_gnt;
  always @(posedge clk) begin
    pre_wr  = wr_en;
    pre_gnt = gnt;
  end

  int occ;
  bit fifo_auto, fifo_reads;
  int mode;  // 0 manual, 1 hold all and refresh data on grant, 2 random requesters

  task automatic tick();
    @(posedge clk);
    #1;
    if (fifo_auto) begin
      if (pre_wr) begin
        check("no_overflow", (occ < DEPTH), 1);
        occ++;
      end
      if (fifo_reads && occ > 0 && $urandom_range(0, 2) == 0) occ--;
      fifo_counter = 8'(occ);
      buf_full     = (occ >= DEPTH);
    end
    for (int i = 0; i < N; i++) begin
      if (mode == 1) begin
        if (pre_gnt[i]) req_data[i*W +: W] = 8'($urandom);
      end else if (mode == 2) begin
        if (req[i] && pre_gnt[i]) begin
          req[i] = ($urandom_range(0, 3) != 0);
          req_data[i*W +: W] = 8'($urandom);
        end else if (!req[i] && $urandom_range(0, 2) == 0) begin
          req[i] = 1'b1;
          req_data[i*W +: W] = 8'($urandom);
        end
      end
    end
  endtask

  initial begin
    logic [3:0] exp_prio;
    bit found;
    rst = 1'b1; req = '0; req_data = '0; buf_full = 1'b0; fifo_counter = 8'd0;
    occ = 0; fifo_auto = 1'b1; fifo_reads = 1'b0; mode = 0;
    repeat (3) tick();
    rst = 1'b0;

    // Full rotation from reset: 4x0, idle, 4x1, idle, 4x2, idle, 4x3, idle, 4x0
    mode = 1;
    req  = 4'b1111;
    for (int i = 0; i < N; i++) req_data[i*W +: W] = 8'($urandom);
    tick();
    for (int i = 0; i < 25; i++) begin
      int pos, own;
      pos = i % 5;
      own = (i / 5) % 4;
      @(negedge clk);
      check("rot_gnt", gnt, (pos < 4) ? (1 << own) : 0);
      check("rot_wr_en", wr_en, (pos != 0));
      tick();
    end
    mode = 0; req = '0;
    repeat (3) tick();
    occ = 0; fifo_counter = 8'd0;

    // Single write from requester 1
    req_data[1*W +: W] = 8'hAA;
    req = 4'b0010;
    tick();
    @(negedge clk); check("single_gnt", gnt, 4'b0010);
    tick(); req = '0;
    @(negedge clk); check("single_wr_en", wr_en, 1); check("single_buf_in", buf_in, 8'hAA);
    tick();
    @(negedge clk); check("single_busy", busy, 0);

    // Occupancy throttle with a manually driven counter
    fifo_auto = 1'b0; fifo_counter = 8'd63; buf_full = 1'b0;
    mode = 1; req = 4'b1000;
    tick();
    @(negedge clk); check("thr_first_gnt", gnt, 4'b1000);
    tick();
    @(negedge clk); check("thr_inflight_gnt", gnt, 0);
    tick(); fifo_counter = 8'd64;
    @(negedge clk); check("thr_counted_gnt", gnt, 0);
    tick(); fifo_counter = 8'd62;
    @(negedge clk); check("thr_resume_gnt", gnt, 4'b1000);
    tick(); fifo_counter = 8'd10; buf_full = 1'b1;
    @(negedge clk); check("thr_buf_full_gnt", gnt, 0);
    tick(); buf_full = 1'b0; fifo_counter = 8'd0; req = '0; mode = 0;
    repeat (2) tick();
    occ = 0; fifo_auto = 1'b1;

    // Early release by requester 2 after two words; 1 and 3 pending
    req_data[2*W +: W] = 8'h21;
    req = 4'b0100;
    tick();
    @(negedge clk); check("er_gnt1", gnt, 4'b0100);
    tick(); req_data[2*W +: W] = 8'h22;
    @(negedge clk); check("er_gnt2", gnt, 4'b0100);
    tick(); req = 4'b1010;
    @(negedge clk); check("er_release_gnt", gnt, 0);
    tick();
    @(negedge clk); check("er_idle_busy", busy, 0); check("er_last_owner", cur_owner, 2);
    tick();
    @(negedge clk); check("er_winner", gnt, 4'b1000);
    tick(); req = '0;
    repeat (2) tick();

    // Reset in the middle of a burst
    mode = 1; req = 4'b1111;
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      tick();
      if (wr_en) found = 1'b1;
    end
    check("mb_wait_wr_en", found, 1);
    #2;
    rst = 1'b1;
    exp_q.delete();
    #1;
    check("mb_wr_en", wr_en, 0); check("mb_buf_in", buf_in, 0);
    check("mb_gnt", gnt, 0);     check("mb_busy", busy, 0);
    tick(); rst = 1'b0;
    @(negedge clk); check("mb_idle_gnt", gnt, 0);
    tick();
    @(negedge clk); check("mb_first_winner", gnt, 4'b0001);

    // Priority option: last owner 0, then requesters 0 and 2 in IDLE
    mode = 0;
    tick(); req = '0;
    tick(); req = 4'b0101;
    @(negedge clk); check("prio_idle_gnt", gnt, 0);
    tick();
`ifdef FIFO_ARB_PRIO0_EN
    exp_prio = 4'b0001;
`else
    exp_prio = 4'b0100;
`endif
    @(negedge clk); check("prio_winner", gnt, exp_prio);
    tick(); req = '0;
    repeat (3) tick();

    // Randomized traffic against a FIFO that drains slowly
    occ = 0; fifo_reads = 1'b1; mode = 2;
    repeat (3000) tick();
    mode = 0; req = '0;
    repeat (10) tick();
    check("scoreboard_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write-port arbiter that shares the single write port of the team's 8-bit FIFO between `N_REQ` producers. It grants one requester ownership of the port for a burst of up to `BURST` words, then rotates ownership. It registers the winning word onto `buf_in`/`wr_en`, and it throttles on FIFO occupancy so that no write is ever issued into a full FIFO, including writes already in flight. It sits directly in front of the FIFO write side, in the write clock domain.

## Interface
- `N_REQ`, 4: number of requesters, 2..8.
- `DATA_W`, 8: data width, matching the FIFO `buf_in`.
- `BURST`, 4: maximum words accepted per ownership, 1..255.
- `DEPTH`, 64: FIFO capacity in words, at most 255.
- `clk` in 1: single clock; all logic is rising-edge.
- `rst` in 1: reset, asynchronous and active-high.
- `req` in `N_REQ`: `req[i]` high means requester i has a word on its data slice.
- `req_data` in `N_REQ*DATA_W`: requester i's data is at `[i*DATA_W +: DATA_W]`.
- `gnt` out `N_REQ`: one-hot, combinational; `gnt[i]` high means requester i's word is accepted on this edge.
- `buf_full` in 1: FIFO full flag.
- `fifo_counter` in 8: FIFO occupancy.
- `buf_in` out `DATA_W`: registered write data to the FIFO.
- `wr_en` out 1: registered write strobe to the FIFO.
- `busy` out 1: high in OWN state.
- `cur_owner` out `$clog2(N_REQ)`: index of the current or last owner.

## Operation
- The state machine has two states: IDLE and OWN.
- **IDLE:**
  - No grants are issued.
  - If any `req` bit is high, the next owner is the first requester with `req` high, searching upward from `last_owner+1` modulo `N_REQ`.
  - The FSM then goes to OWN, with `cur_owner` set to the winner and `burst_cnt` = 0.
- **OWN:** `accept = req[cur_owner] & ~buf_full & (fifo_counter + wr_en < DEPTH)`.
  - The sum is computed 9 bits wide.
  - `wr_en` counts the write in flight that the FIFO has not yet counted.
- **On accept:**
  - `gnt[cur_owner]` = 1.
  - On the next edge: `buf_in <= req_data` slice, `wr_en <= 1`, and `burst_cnt` increments.
- **No accept:** `wr_en <= 0` on the next edge.
- **Leave OWN for IDLE, with `last_owner <= cur_owner`:**
  - after the accept that makes `burst_cnt == BURST`; or
  - when `req[cur_owner]` is low.
- **Stall:** while only the occupancy condition blocks, the FSM stays in OWN and `burst_cnt` freezes. Dropping `req` during a stall releases ownership.
- **Requester rule:** hold `req[i]` and the data slice stable until the cycle `gnt[i]` is high. `req` may drop in the cycle after a grant.
- **Reset values:** state IDLE, `last_owner` = `N_REQ-1` (so requester 0 wins first), `burst_cnt` = 0, `buf_in` = 0, `wr_en` = 0, `busy` = 0, `cur_owner` = 0, `gnt` = 0.
- **Reset mid-burst:** all outputs clear immediately and the in-flight write is discarded.

## Timing
- The word reaches `buf_in`/`wr_en` 1 cycle after its `gnt`. Peak rate is 1 word per cycle within a burst.
- Between owners, exactly one IDLE cycle with no grant is inserted.
- Request to first grant takes 1 cycle from IDLE: `req` is sampled at edge N, and `gnt` is high during cycle N+1.
- `gnt` depends combinationally on `req`, `buf_full` and `fifo_counter`. There is no other combinational input-to-output path.

## Configuration
- **`FIFO_ARB_PRIO0_EN` defined:**
  - In IDLE, if `req[0]` is high, requester 0 always wins, regardless of `last_owner`.
  - Otherwise round-robin applies as above.
  - The burst limit still applies to requester 0.
- **`FIFO_ARB_PRIO0_EN` undefined:** pure round-robin; no requester has precedence.

## Test plan
- **Single write:** `req[1]` = 1 with 0xAA.
  - Cycle after the request: `gnt` = 0010.
  - Next cycle: `wr_en` = 1, `buf_in` = 0xAA.
  - Drop `req` and the FSM returns to IDLE.
- **Full rotation:** all four requesters held high, `BURST`=4, FIFO empty.
  - Grants are 4×0, idle, 4×1, idle, 4×2, idle, 4×3, idle, 4×0.
  - `wr_en` pattern is 1111 0 repeating.
- **Occupancy throttle:**
  - `fifo_counter`=63, `DEPTH`=64: exactly one grant, then no grant while `wr_en`=1 and while `fifo_counter` is 64.
  - Counter drops to 62: grants resume.
  - `buf_full`=1 forces `gnt`=0.
- **Early release:** requester 2 drops `req` after 2 accepted words.
  - The FSM goes to IDLE next and `last_owner`=2.
  - With requesters 1 and 3 pending, requester 3 wins.
- **Reset mid-burst:** assert `rst` during `wr_en`=1.
  - `wr_en`, `buf_in`, `gnt` and `busy` read 0 before the next edge.
  - After release with all requesting, requester 0 wins first.
- **Macro:** `last_owner`=0, then `req[0]` and `req[2]` high in IDLE.
  - Requester 0 wins with `FIFO_ARB_PRIO0_EN` defined.
  - Requester 2 wins without it.
